// File: rtl/ifetch_seq.sv
// Sequential instruction-fetch stage: holds the PC, fetches over a req/ack
// handshake with timeout, and computes the next PC from branch/jump/jr controls.
module ifetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] PC_plus_4,
    output logic [31:0] link_addr,
    input  logic [31:0] Addr_Result,
    input  logic        Zero,
    input  logic [31:0] Read_data_1,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        stall,
    output logic        fetch_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pc4_q, pc4_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          req_q, req_d;
    logic [31:0]   link_q, link_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   target_s;
    logic [31:0]   next_pc_s;

    // Next-PC selection: jr beats jumps, jumps beat taken branches.
    always_comb begin
        target_s = pc4_q;
        if (Jr) begin
            target_s = Read_data_1;
        end else if (Jmp || Jal) begin
            target_s = {pc4_q[31:28], instr_q[25:0], 2'b00};
        end else if ((Branch && Zero) || (nBranch && !Zero)) begin
            target_s = Addr_Result << 2;
        end else begin
            target_s = pc4_q;
        end
        next_pc_s = target_s & ~32'h0000_0003;
    end

    // Fetch FSM next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
        link_d  = link_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
                req_d   = 1'b1;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_HALT;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    pc_d    = next_pc_s;
                    pc4_d   = next_pc_s + 32'd4;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    if (Jal) begin
                        link_d = pc4_q;
                    end else begin
                        link_d = link_q;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_HALT: begin
                valid_d = 1'b0;
                req_d   = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + 32'd4;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            link_q  <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            link_q  <= link_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign inst_valid  = valid_q;
    assign pc          = pc_q;
    assign PC_plus_4   = pc4_q;
    assign link_addr   = link_q;
    assign fetch_err   = err_q;

endmodule

// File: doc/ifetch_seq.md
Name: ifetch_seq

Overview:
- Sequential instruction-fetch stage of the CS202 MIPS core; sits directly upstream of the execute unit.
- Holds the PC and fetches from a variable-latency instruction memory over a req/ack handshake.
- Presents the instruction, PC_plus_4 and the link address to decode/execute.
- Selects the next PC from the execute unit's Addr_Result/Zero, the jump fields, or Read_data_1 for jr.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
- TIMEOUT, 16, max cycles in WAIT before the fetch is declared failed.

Ports:
- clock  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the fetch (equals pc).
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- Instruction  output  32  registered instruction for decode/execute.
- inst_valid  output  1  Instruction is live this cycle (ISSUE state).
- pc  output  32  current PC.
- PC_plus_4  output  32  pc+4, to execute unit.
- link_addr  output  32  pc+4 captured at jal ISSUE, for $31 write.
- Addr_Result  input  32  branch target word index from execute unit.
- Zero  input  1  execute unit zero flag.
- Read_data_1  input  32  rs value for jr.
- Branch  input  1  beq.
- nBranch  input  1  bne.
- Jmp  input  1  j.
- Jal  input  1  jal.
- Jr  input  1  jr.
- stall  input  1  downstream memory stage busy; holds ISSUE.
- fetch_err  output  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, Instruction=0, inst_valid=0, imem_req=0, link_addr=0, fetch_err=0, state=IDLE.
  - Reset asserted mid-WAIT aborts the fetch; a late imem_ack after reset release is ignored unless the state is WAIT.
- FSM states: IDLE, WAIT, ISSUE, HALT.
- IDLE -> WAIT after exactly one cycle; imem_req=1 and imem_addr=pc are asserted on entry to WAIT.
- WAIT:
  - imem_req stays 1 until imem_ack.
  - On imem_ack: Instruction<=imem_rdata, imem_req<=0, go ISSUE.
  - imem_ack in the same cycle WAIT is entered is legal; latency is then 1.
  - Counter counts cycles in WAIT; reaching TIMEOUT without ack -> fetch_err=1, imem_req=0, go HALT.
- ISSUE:
  - inst_valid=1.
  - If stall=1, remain in ISSUE with every output held.
  - If stall=0, load pc<=next_pc, go IDLE. Minimum 3 cycles per instruction.
- HALT: absorbing; inst_valid=0, imem_req=0; only reset exits.
- next_pc priority, evaluated in ISSUE with stall=0:
  1. Jr: Read_data_1.
  2. Jmp or Jal: {PC_plus_4[31:28], Instruction[25:0], 2'b00}.
  3. (Branch & Zero) | (nBranch & ~Zero): {Addr_Result[29:0], 2'b00}.
  4. Otherwise: PC_plus_4.
- Multiple control inputs asserted together resolve by the priority above.
- jal: link_addr<=PC_plus_4 on the ISSUE-exit edge; otherwise link_addr holds.
- PC_plus_4 = pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- pc[1:0] are forced to 0 on every load, including jr with a misaligned Read_data_1.
- Control inputs are sampled only in ISSUE; values in other states are ignored.

Test Plan:
- Reset then ack in the first WAIT cycle with rdata=0x2001_0005 -> Instruction=0x2001_0005, inst_valid high 1 cycle, next fetch at pc=0x4.
- pc=0x10, Branch=1, Zero=1, Addr_Result=0x20 -> next imem_addr=0x80; same with Zero=0 -> 0x14.
- pc=0x0040_0008, Jal=1, Instruction[25:0]=0x010_0000 -> pc=0x0040_0000, link_addr=0x0040_000C.
- Jr=1, Jmp=1 together, Read_data_1=0x1237 -> pc=0x1234 (jr wins, low bits cleared).
- stall=1 for 5 cycles in ISSUE -> Instruction and inst_valid held for 5+1 cycles, pc unchanged until stall drops; imem_ack withheld for 16 cycles -> fetch_err=1, HALT, imem_req=0.
- rst_n pulsed low mid-WAIT at pc=0x40 -> pc=RESET_PC immediately (async); subsequent fetch starts from 0x0.
